// File: rtl/rv_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding ibus read, small in-order buffer to decode.
// Define FETCH_SKID_EN for a 2-entry buffer; otherwise the buffer is a single register.
module rv_fetch_ctrl (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:2] i_pc,
  input  logic        i_redirect,
  output logic        o_fetch_stall,
  output logic        o_ibus_req,
  output logic [31:2] o_ibus_addr,
  input  logic        i_ibus_gnt,
  input  logic        i_ibus_rvalid,
  input  logic [31:0] i_ibus_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:2] o_inst_pc,
  input  logic        i_decode_ready
);

`ifdef FETCH_SKID_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:2] pend_pc;
  logic        head_vld;
  logic [31:0] head_inst;
  logic [31:2] head_pc;
  logic [1:0]  count;
  logic        pop, space, grant, wr, to_head;

`ifdef FETCH_SKID_EN
  logic        skid_vld;
  logic [31:0] skid_inst;
  logic [31:2] skid_pc;
  logic        to_skid;

  assign count   = {1'b0, head_vld} + {1'b0, skid_vld};
  // A new word lands in the head when the head is free after this cycle's pop.
  assign to_head = wr && (!head_vld || (pop && !skid_vld));
  assign to_skid = wr && !to_head;
`else
  assign count   = {1'b0, head_vld};
  assign to_head = wr;
`endif

  assign pop   = head_vld && i_decode_ready;
  assign space = (count - {1'b0, pop}) < DEPTH;

  always_comb begin
    state_nxt     = state;
    wr            = 1'b0;
    o_ibus_req    = (state == S_REQ) && space && !i_redirect;
    o_ibus_addr   = i_pc;
    grant         = o_ibus_req && i_ibus_gnt;
    o_fetch_stall = (state == S_IDLE) ? 1'b0 : !grant;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (grant) state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_ibus_rvalid) begin
          wr        = !i_redirect;
          state_nxt = S_REQ;
        end else if (i_redirect) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: if (i_ibus_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (grant) pend_pc <= i_pc;
  end

  // Head entry: payload holds its last value whenever the entry is invalidated.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      head_vld  <= 1'b0;
      head_inst <= '0;
      head_pc   <= '0;
    end else begin
      if (i_redirect)   head_vld <= 1'b0;
      else if (to_head) head_vld <= 1'b1;
`ifdef FETCH_SKID_EN
      else if (pop)     head_vld <= skid_vld;
`else
      else if (pop)     head_vld <= 1'b0;
`endif
      if (to_head) begin
        head_inst <= i_ibus_rdata;
        head_pc   <= pend_pc;
`ifdef FETCH_SKID_EN
      end else if (pop && skid_vld && !i_redirect) begin
        head_inst <= skid_inst;
        head_pc   <= skid_pc;
`endif
      end
    end
  end

`ifdef FETCH_SKID_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)   skid_vld <= 1'b0;
    else if (i_redirect) skid_vld <= 1'b0;
    else if (to_skid) skid_vld <= 1'b1;
    else if (pop)     skid_vld <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (to_skid) begin
      skid_inst <= i_ibus_rdata;
      skid_pc   <= pend_pc;
    end
  end
`endif

  assign o_inst_valid = head_vld;
  assign o_inst       = head_inst;
  assign o_inst_pc    = head_pc;

endmodule

// File: doc/rv_fetch_ctrl.md
# rv_fetch_ctrl

Instruction-fetch sequencer between the fetch PC register and the instruction bus. It issues one word request per PC and tracks a single outstanding transaction. Returned words go into a small buffer that feeds decode. It drives the fetch stall so the PC advances only when a request is accepted, and discards in-flight or buffered words on an execute redirect.

## Interface
Parameters:
- none; buffer depth is set by `FETCH_SKID_EN` (see Configuration).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_pc  in  [31:2]  current fetch PC from the fetch unit.
- i_redirect  in  1  execute-stage PC redirect. The fetch unit loads the target on the same edge.
- o_fetch_stall  out  1  hold request to the fetch unit. When low, the PC advances.
- o_ibus_req  out  1  instruction bus address request.
- o_ibus_addr  out  [31:2]  request word address, equal to i_pc.
- i_ibus_gnt  in  1  address accepted. Sampled only while o_ibus_req is high.
- i_ibus_rvalid  in  1  read data valid, arriving one or more cycles after gnt.
- i_ibus_rdata  in  [31:0]  read data.
- o_inst_valid  out  1  buffer head valid.
- o_inst  out  [31:0]  buffer head instruction.
- o_inst_pc  out  [31:2]  word PC of the buffer head.
- i_decode_ready  in  1  decode accepts the head. A pop occurs when o_inst_valid && i_decode_ready.

## Operation
- States:
  - IDLE: reset state. Lasts exactly one cycle after reset release, then goes to REQ. o_fetch_stall is low in IDLE, which steps the fetch PC from RESET_ADDR-1 to RESET_ADDR.
  - REQ: issuing.
  - WAIT: one request outstanding.
  - FLUSH: an outstanding response is to be discarded.
- Space condition: space = (buffer count − pop this cycle) < DEPTH.
- o_ibus_req = (state==REQ) && space && !i_redirect.
- o_ibus_addr = i_pc, driven combinationally.
- o_fetch_stall = !(o_ibus_req && i_ibus_gnt) in REQ/WAIT/FLUSH, and 0 in IDLE.
- REQ transitions:
  - gnt → latch i_pc into the pending PC, go to WAIT.
  - No gnt → stay in REQ.
- WAIT transitions:
  - rvalid && !redirect → write {rdata, pending PC} to the buffer tail, go to REQ.
  - rvalid && redirect → drop the data, go to REQ.
  - !rvalid && redirect → go to FLUSH.
  - Otherwise stay in WAIT.
- FLUSH transitions:
  - rvalid → drop the data, go to REQ.
  - Redirect while in FLUSH → stay in FLUSH.
- Any redirect, in any state, empties the buffer on that edge and overrides a simultaneous pop or write.
- Buffer is an in-order FIFO with pointers that wrap modulo DEPTH. A write never finds the buffer full, because space was reserved at request time.
- Outputs when the buffer is empty: o_inst and o_inst_pc hold their last values; o_inst_valid=0.
- An rvalid seen in REQ or IDLE is a protocol error. It is ignored (no buffer write).

## Timing
- Reset values:
  - state=IDLE, buffer empty.
  - o_inst_valid=0, o_inst=0, o_inst_pc=0.
  - o_ibus_req=0, o_fetch_stall=0.
- Request-to-buffer latency:
  - gnt in cycle N → earliest rvalid in N+1.
  - rvalid in cycle M → o_inst_valid=1 in M+1.
- Throughput:
  - Minimum two cycles per word (REQ→WAIT→REQ).
  - A back-to-back rvalid/gnt pair issues the next request in the cycle after rvalid.
- Redirect in cycle R:
  - o_ibus_req=0 in R.
  - o_inst_valid=0 in R+1.
  - The first request at the new PC is issued in R+1 if the state is REQ. Otherwise it is issued in the cycle after the discarded rvalid.
- Reset mid-transaction: state returns to IDLE on the reset edge. A late rvalid after reset arrives in IDLE/REQ and is ignored per the rule above.

## Configuration
- `FETCH_SKID_EN` defined:
  - DEPTH=2, giving a 2-entry FIFO.
  - A new request may issue while one word is held and decode is stalled.
- Undefined:
  - DEPTH=1, a single register.
  - A request issues only when the buffer is empty, or is popped in the same cycle.
  - Pointers degenerate to a valid bit.

## Test plan
- Reset release with RESET_ADDR=0:
  - Stall is low for 1 cycle and PC becomes 0.
  - req addr 0; gnt; rvalid data 0x00000013 → o_inst_valid with o_inst=0x00000013, o_inst_pc=0.
- Decode ready held low, gnt/rvalid always 1:
  - With `FETCH_SKID_EN`: exactly 2 words buffered, then o_ibus_req=0.
  - Without it: 1 word buffered, then o_ibus_req=0.
- Redirect in WAIT to 0x100/4:
  - The late rvalid of 0xDEADBEEF is dropped, with no o_inst_valid.
  - Next request addr=0x40 and its data appears with o_inst_pc=0x40.
- Redirect in the same cycle as rvalid, with the buffer holding 1 word → the buffer empties next cycle and the returned word is never presented.
- gnt delayed 3 cycles → o_fetch_stall stays high and o_ibus_addr stays stable for all 3 cycles; the PC advances exactly once.
- Reset asserted in WAIT, then rvalid during IDLE → no buffer write and normal restart at RESET_ADDR.
